ebus_io_ctl: RTL and testbench

//  EBOX-side EBUS I/O transaction sequencer. Turns one EBOX I/O request (CONO/CONI/DATAO/DATAI)

---
 rtl/ebus_io_ctl_pkg.sv | 23 ++
 rtl/ebus_io_timer.sv | 26 ++
 rtl/ebus_io_ctl.sv | 140 ++++++++++++++
 tb/tb_ebus_io_ctl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ebus_io_ctl_pkg.sv
// Shared EBUS definitions for the EBOX I/O sequencer: function codes, bus widths, decode helpers.
package ebus_io_ctl_pkg;

    localparam int EBUS_DEV_W  = 7;
    localparam int EBUS_DATA_W = 36;

    typedef enum logic [2:0] {
        CONO  = 3'b000,
        CONI  = 3'b001,
        DATAO = 3'b010,
        DATAI = 3'b011
    } tEBUSFunc;

    // Function bits use PDP-10 numbering: bit 0 is the MSB.
    function automatic logic isReadFunc(input logic [0:2] f);
        return f[2];
    endfunction

    function automatic logic isReservedFunc(input logic [0:2] f);
        return f[0];
    endfunction

endpackage

// File: rtl/ebus_io_timer.sv
// Down-counter with saturating expiry; times both the SETUP hold-off and the DEMAND/RELEASE abort window.
module ebus_io_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         count,
    input  logic [W-1:0] loadVal,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= loadVal;
        else if (count && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/ebus_io_ctl.sv
// EBOX-side EBUS I/O sequencer: one CONO/CONI/DATAO/DATAI request becomes a CS/func/demand/xfer handshake.
module ebus_io_ctl
    import ebus_io_ctl_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   eboxClk,
    input  logic                   eboxReset,
    input  logic                   ioReq,
    input  logic [0:2]             ioFunc,
    input  logic [3:9]             ioDev,
    input  logic [0:EBUS_DATA_W-1] ioDataOut,
    output logic                   ioBusy,
    output logic                   ioDone,
    output logic                   ioTimeout,
    output logic [0:EBUS_DATA_W-1] ioDataIn,
    output logic [3:9]             ebusCS,
    output logic [0:2]             ebusFunc,
    output logic                   ebusDemand,
    input  logic                   ebusXfer,
    input  logic [0:EBUS_DATA_W-1] ebusDataIn,
    output logic [0:EBUS_DATA_W-1] ebusDataOut,
    output logic                   ebusDriveData
);

    localparam int CNT_MAX = (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LOAD    = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, DEMAND, RELEASE, DONE} tIOState;

    tIOState                state, stateNext;
    logic [0:2]             funcQ;
    logic [3:9]             devQ;
    logic [0:EBUS_DATA_W-1] dataQ, rdData;
    logic                   toFlag;
    logic                   tmrLoad, tmrCount, tmrExpired;
    logic [CNT_W-1:0]       tmrVal;
    logic                   accept, capture, setTo, active;

    ebus_io_timer #(.W(CNT_W)) uTimer (
        .clk     (eboxClk),
        .rst     (eboxReset),
        .load    (tmrLoad),
        .count   (tmrCount),
        .loadVal (tmrVal),
        .expired (tmrExpired)
    );

    always_ff @(posedge eboxClk or posedge eboxReset) begin
        if (eboxReset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        tmrLoad   = 1'b0;
        tmrVal    = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        setTo     = 1'b0;
        unique case (state)
            IDLE: if (ioReq) begin
                accept = 1'b1;
                if (isReservedFunc(ioFunc)) begin
                    stateNext = DONE;
                    setTo     = 1'b1;
                end else begin
                    stateNext = SETUP;
                    tmrLoad   = 1'b1;
                    tmrVal    = SETUP_LOAD;
                end
            end
            // A device still holding xfer from a previous cycle blocks demand indefinitely.
            SETUP: if (tmrExpired && !ebusXfer) begin
                stateNext = DEMAND;
                tmrLoad   = 1'b1;
                tmrVal    = TO_LOAD;
            end
            DEMAND: if (ebusXfer) begin
                stateNext = RELEASE;
                capture   = isReadFunc(funcQ);
                tmrLoad   = 1'b1;
                tmrVal    = TO_LOAD;
            end else if (tmrExpired) begin
                stateNext = DONE;
                setTo     = 1'b1;
            end
            RELEASE: if (!ebusXfer) begin
                stateNext = DONE;
            end else if (tmrExpired) begin
                stateNext = DONE;
                setTo     = 1'b1;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign tmrCount = (state == SETUP) || (state == DEMAND) || (state == RELEASE);

    // Read data is cleared at accept so a timed-out read returns zero.
    always_ff @(posedge eboxClk or posedge eboxReset) begin
        if (eboxReset) begin
            funcQ  <= '0;
            devQ   <= '0;
            dataQ  <= '0;
            rdData <= '0;
            toFlag <= 1'b0;
        end else begin
            if (accept) begin
                funcQ  <= ioFunc;
                devQ   <= ioDev;
                dataQ  <= ioDataOut;
                rdData <= '0;
                toFlag <= setTo;
            end else if (setTo) begin
                toFlag <= 1'b1;
            end
            if (capture)
                rdData <= ebusDataIn;
        end
    end

    assign active        = (state == SETUP) || (state == DEMAND) || (state == RELEASE);
    assign ioBusy        = (state != IDLE);
    assign ioDone        = (state == DONE);
    assign ioTimeout     = ioDone && toFlag;
    assign ioDataIn      = rdData;
    assign ebusCS        = active ? devQ : '0;
    assign ebusFunc      = active ? funcQ : '0;
    assign ebusDemand    = (state == DEMAND);
    assign ebusDriveData = active && !isReadFunc(funcQ);
    assign ebusDataOut   = ebusDriveData ? dataQ : '0;

endmodule

// File: tb/tb_ebus_io_ctl.sv
// Directed bench for ebus_io_ctl: transaction table with a simple device model, plus hand-written corner sequences.
module tb_ebus_io_ctl;
    import ebus_io_ctl_pkg::*;

    logic        eboxClk = 1'b0;
    logic        eboxReset = 1'b1;
    logic        ioReq = 1'b0;
    logic [0:2]  ioFunc = '0;
    logic [3:9]  ioDev = '0;
    logic [0:35] ioDataOut = '0;
    logic        ioBusy, ioDone, ioTimeout;
    logic [0:35] ioDataIn;
    logic [3:9]  ebusCS;
    logic [0:2]  ebusFunc;
    logic        ebusDemand;
    logic        ebusXfer = 1'b0;
    logic [0:35] ebusDataIn = '0;
    logic [0:35] ebusDataOut;
    logic        ebusDriveData;

    ebus_io_ctl #(.SETUP_CYC(2), .TIMEOUT_CYC(64)) dut (
        .eboxClk(eboxClk), .eboxReset(eboxReset), .ioReq(ioReq), .ioFunc(ioFunc), .ioDev(ioDev),
        .ioDataOut(ioDataOut), .ioBusy(ioBusy), .ioDone(ioDone), .ioTimeout(ioTimeout),
        .ioDataIn(ioDataIn), .ebusCS(ebusCS), .ebusFunc(ebusFunc), .ebusDemand(ebusDemand),
        .ebusXfer(ebusXfer), .ebusDataIn(ebusDataIn), .ebusDataOut(ebusDataOut),
        .ebusDriveData(ebusDriveData)
    );

    always #5 eboxClk = ~eboxClk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  func;
        logic [6:0]  dev;
        logic [35:0] data;
        int          ack;       // demand cycles before xfer; 0 = device never answers
        int          hold;      // cycles xfer stays high after rising
        logic [35:0] devData;
        int          expDoneAt; // observation index of ioDone, 0 = cycle after accept edge
        logic        expTo;
        logic [35:0] expDataIn;
        logic        expDrive;
        int          expDemand;
    } tVec;

    tVec vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge eboxClk);
        #1;
    endtask

    task automatic runVec(input tVec v, input string tag);
        int   dc = 0, hc = 0, doneCnt = 0, doneAt = -1, demCyc = 0, busBad = 0;
        logic xOn = 1'b0, xDone = 1'b0, toAt = 1'b0;
        logic [35:0] dAt = '0;
        ioReq = 1'b1; ioFunc = v.func; ioDev = v.dev; ioDataOut = v.data;
        step;
        ioReq = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (ioDone) begin
                doneCnt++; doneAt = i; toAt = ioTimeout; dAt = ioDataIn;
                if (ebusCS != 0 || ebusFunc != 0 || ebusDemand || ebusDriveData || ebusDataOut != 0)
                    busBad++;
            end else if (ioBusy) begin
                if (ebusCS !== v.dev || ebusFunc !== v.func || ebusDriveData !== v.expDrive ||
                    ebusDataOut !== (v.expDrive ? v.data : 36'd0))
                    busBad++;
            end
            if (ebusDemand) begin demCyc++; dc++; end
            if (!xOn && !xDone && v.ack != 0 && ebusDemand && dc == v.ack) begin
                ebusXfer = 1'b1; ebusDataIn = v.devData; xOn = 1'b1; hc = 0;
            end else if (xOn) begin
                hc++;
                if (hc == v.hold) begin ebusXfer = 1'b0; ebusDataIn = '0; xOn = 1'b0; xDone = 1'b1; end
            end
            if (doneCnt != 0) break;
            step;
        end
        ebusXfer = 1'b0; ebusDataIn = '0;
        check({tag, " doneSeen"}, 64'(doneCnt), 64'd1);
        check({tag, " doneAt"}, 64'(doneAt), 64'(v.expDoneAt));
        check({tag, " timeout"}, 64'(toAt), 64'(v.expTo));
        check({tag, " dataIn"}, 64'(dAt), 64'(v.expDataIn));
        check({tag, " demandCycles"}, 64'(demCyc), 64'(v.expDemand));
        check({tag, " busBad"}, 64'(busBad), 64'd0);
        step;
        check({tag, " busyAfter"}, 64'(ioBusy), 64'd0);
        check({tag, " doneAfter"}, 64'(ioDone), 64'd0);
    endtask

    initial begin
        int demEarly, extra;
        //            func    dev    data               ack hold devData            doneAt to   dataIn             drv  dem
        vecs[0] = '{3'b010, 7'o20, 36'o123456654321, 3, 2,    36'o0,             7,  1'b0, 36'o0,             1'b1, 3};
        vecs[1] = '{3'b011, 7'o21, 36'o1,            2, 1,    36'o777000000777,  5,  1'b0, 36'o777000000777,  1'b0, 2};
        vecs[2] = '{3'b000, 7'o03, 36'o525252525252, 0, 0,    36'o0,             66, 1'b1, 36'o0,             1'b1, 64};
        vecs[3] = '{3'b001, 7'o04, 36'o0,            1, 1000, 36'o543210012345,  67, 1'b1, 36'o543210012345,  1'b0, 1};
        vecs[4] = '{3'b100, 7'o05, 36'o7,            0, 0,    36'o0,             0,  1'b1, 36'o0,             1'b0, 0};
        vecs[5] = '{3'b011, 7'o177, 36'o0,           1, 1,    36'o1,             4,  1'b0, 36'o1,             1'b0, 1};
        vecs[6] = '{3'b001, 7'o06, 36'o0,            0, 0,    36'o0,             66, 1'b1, 36'o0,             1'b0, 64};

        #2;
        check("rst busy", 64'(ioBusy), 64'd0);
        check("rst done", 64'(ioDone), 64'd0);
        check("rst demand", 64'(ebusDemand), 64'd0);
        check("rst cs", 64'(ebusCS), 64'd0);
        check("rst drive", 64'(ebusDriveData), 64'd0);
        check("rst dataIn", 64'(ioDataIn), 64'd0);
        step; step;
        eboxReset = 1'b0;
        step;

        for (int k = 0; k < 7; k++) runVec(vecs[k], $sformatf("vec%0d", k));

        // Stale xfer at accept holds off demand; ioReq during DEMAND is ignored.
        ebusXfer = 1'b1; ioReq = 1'b1; ioFunc = 3'b011; ioDev = 7'o33;
        step;
        ioReq = 1'b0;
        demEarly = 0;
        for (int i = 0; i < 5; i++) begin
            if (ebusDemand) demEarly++;
            if (i == 4) ebusXfer = 1'b0;
            step;
        end
        check("stale demandEarly", 64'(demEarly), 64'd0);
        check("stale demandRise", 64'(ebusDemand), 64'd1);
        ioReq = 1'b1; ioFunc = 3'b000;
        step;
        ioReq = 1'b0; ebusXfer = 1'b1; ebusDataIn = 36'o42;
        step;
        check("stale released", 64'(ebusDemand), 64'd0);
        ebusXfer = 1'b0; ebusDataIn = '0;
        step;
        check("stale done", 64'(ioDone), 64'd1);
        check("stale dataIn", 64'(ioDataIn), 64'o42);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            step;
            if (ioDone || ioBusy) extra++;
        end
        check("ignoredReq extra", 64'(extra), 64'd0);

        // Reset mid-DEMAND clears the bus at once and gives no completion.
        ioReq = 1'b1; ioFunc = 3'b000; ioDev = 7'o55;
        step;
        ioReq = 1'b0;
        repeat (4) step;
        check("midrst demandBefore", 64'(ebusDemand), 64'd1);
        eboxReset = 1'b1;
        #1;
        check("midrst demand", 64'(ebusDemand), 64'd0);
        check("midrst cs", 64'(ebusCS), 64'd0);
        check("midrst busy", 64'(ioBusy), 64'd0);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            step;
            if (ioDone) extra++;
        end
        eboxReset = 1'b0;
        step;
        if (ioDone) extra++;
        check("midrst noDone", 64'(extra), 64'd0);
        runVec(vecs[1], "postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
